// File: rtl/cache_req_pkg.sv
// Shared types for the cache request initiator.
// Cache port widths, FSM states and the queued request entry.
package cache_req_pkg;

  localparam int NUM_WAYS   = 4;
  localparam int ADDR_WIDTH = 16;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ISSUE,
    CAPTURE,
    RESPOND
  } state_t;

  typedef struct packed {
    logic                  os;
    logic [NUM_WAYS-1:0]   hitmap;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  domain;
  } req_entry_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cache_req_fifo.sv
// Request FIFO; pointers carry one extra wrap bit
// so that full and empty can be told apart.
module cache_req_fifo
  import cache_req_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = req_entry_t
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cache_req_initiator.sv
// Queues OS/user requests and issues them one at a time to the cache.
// Define HIT_STATS_EN to add per-domain saturating hit/miss counters.
module cache_req_initiator
  import cache_req_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int INIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_os,
  input  logic [NUM_WAYS-1:0]   req_hitmap,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_domain,
  output logic                  cache_reset,
  output logic                  os_req,
  output logic                  user_req,
  output logic [NUM_WAYS-1:0]   hitmap,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic                  hit,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic                  rsp_os,
  output logic                  rsp_domain,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
`ifdef HIT_STATS_EN
  output logic [7:0]            hits_victim,
  output logic [7:0]            hits_attacker,
  output logic [7:0]            miss_victim,
  output logic [7:0]            miss_attacker,
`endif
  output logic                  busy
);

  localparam int CW = $clog2(INIT_CYCLES + 1);

  state_t        state;
  logic [CW-1:0] init_cnt;
  req_entry_t    cur;
  req_entry_t    head;
  req_entry_t    push_data;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  assign push_data = {req_os, req_hitmap, req_addr, req_domain};
  assign req_ready = (state != INIT) && !full;
  assign push      = req_valid && req_ready;
  assign pop       = !empty &&
                     ((state == IDLE) || (state == RESPOND && rsp_ready));
  assign busy      = (state != IDLE) || !empty;

  cache_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (req_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= INIT;
      init_cnt    <= '0;
      cache_reset <= 1'b1;
      os_req      <= 1'b0;
      user_req    <= 1'b0;
      hitmap      <= '0;
      addr        <= '0;
      cur         <= '0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_os      <= 1'b0;
      rsp_domain  <= 1'b0;
      rsp_addr    <= '0;
    end else begin
      os_req   <= 1'b0;
      user_req <= 1'b0;
      // pop only happens on the edge that enters ISSUE
      if (pop) begin
        cur      <= head;
        os_req   <= head.os;
        user_req <= !head.os;
        hitmap   <= head.hitmap;
        addr     <= head.addr;
      end
      unique case (state)
        INIT: begin
          if (init_cnt == CW'(INIT_CYCLES - 1)) begin
            state       <= IDLE;
            cache_reset <= 1'b0;
          end else begin
            init_cnt <= init_cnt + CW'(1);
          end
        end
        IDLE: begin
          if (!empty)
            state <= ISSUE;
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          state      <= RESPOND;
          rsp_valid  <= 1'b1;
          rsp_hit    <= !cur.os && hit;
          rsp_os     <= cur.os;
          rsp_domain <= cur.domain;
          rsp_addr   <= cur.addr;
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= empty ? IDLE : ISSUE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef HIT_STATS_EN
  logic cap_user;

  assign cap_user = (state == CAPTURE) && !cur.os;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hits_victim   <= '0;
      hits_attacker <= '0;
      miss_victim   <= '0;
      miss_attacker <= '0;
    end else if (cap_user) begin
      unique case ({cur.domain, hit})
        2'b00:   miss_victim   <= sat_inc(miss_victim);
        2'b01:   hits_victim   <= sat_inc(hits_victim);
        2'b10:   miss_attacker <= sat_inc(miss_attacker);
        default: hits_attacker <= sat_inc(hits_attacker);
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_cache_req_initiator.sv
// Bench for cache_req_initiator: random and directed traffic
// checked against a queue-based transaction model.
module tb_cache_req_initiator;
  import cache_req_pkg::*;

  localparam int DEPTH = 4;
  localparam int INITC = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_os;
  logic [NUM_WAYS-1:0]   req_hitmap;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_domain;
  logic                  cache_reset;
  logic                  os_req;
  logic                  user_req;
  logic [NUM_WAYS-1:0]   hitmap;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  hit;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_hit;
  logic                  rsp_os;
  logic                  rsp_domain;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  busy;
`ifdef HIT_STATS_EN
  logic [7:0] hits_victim, hits_attacker, miss_victim, miss_attacker;
  logic [7:0] m_hv, m_ha, m_mv, m_ma;
`endif

  always #5 clk = ~clk;

  cache_req_initiator #(
    .FIFO_DEPTH  (DEPTH),
    .INIT_CYCLES (INITC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_os        (req_os),
    .req_hitmap    (req_hitmap),
    .req_addr      (req_addr),
    .req_domain    (req_domain),
    .cache_reset   (cache_reset),
    .os_req        (os_req),
    .user_req      (user_req),
    .hitmap        (hitmap),
    .addr          (addr),
    .hit           (hit),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_hit       (rsp_hit),
    .rsp_os        (rsp_os),
    .rsp_domain    (rsp_domain),
    .rsp_addr      (rsp_addr),
`ifdef HIT_STATS_EN
    .hits_victim   (hits_victim),
    .hits_attacker (hits_attacker),
    .miss_victim   (miss_victim),
    .miss_attacker (miss_attacker),
`endif
    .busy          (busy)
  );

  typedef struct {
    logic                  os;
    logic [NUM_WAYS-1:0]   hm;
    logic [ADDR_WIDTH-1:0] a;
    logic                  dom;
  } txn_t;

  typedef struct {
    logic                  hit;
    logic                  os;
    logic                  dom;
    logic [ADDR_WIDTH-1:0] a;
  } rsp_t;

  txn_t acc_q[$];
  rsp_t rsp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int init_left = INITC;
  int due = 0;
  int n_acc_dut = 0;
  int n_os_cyc = 0;
  bit arm = 0;
  bit hit_val = 0;
  bit force_hit = 0;
  bit exp_issue = 0;
  logic [NUM_WAYS-1:0]   last_hm = '0;
  logic [ADDR_WIDTH-1:0] last_a = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic rand_req(input int pct);
    req_valid  = ($urandom_range(0, 99) < pct);
    req_os     = 1'($urandom);
    req_hitmap = NUM_WAYS'($urandom);
    req_addr   = ADDR_WIDTH'($urandom);
    req_domain = 1'($urandom);
  endtask

  // one clock: settle the coming edge in the model, then check at negedge
  task automatic tick();
    txn_t t;
    bit   hv;
    logic iss;
    if (!reset_n) begin
      acc_q.delete();
      rsp_q.delete();
      due = 0;
      arm = 0;
      exp_issue = 0;
      last_hm = '0;
      last_a = '0;
      init_left = INITC;
`ifdef HIT_STATS_EN
      m_hv = 0; m_ha = 0; m_mv = 0; m_ma = 0;
`endif
    end else begin
      if (rsp_ready && rsp_q.size() > 0 && due == 0)
        rsp_q.delete(0);
      exp_issue = init_left == 0 && rsp_q.size() == 0 && acc_q.size() > 0;
      if (req_valid && req_ready)
        n_acc_dut++;
      if (req_valid && init_left == 0 && acc_q.size() < DEPTH)
        acc_q.push_back('{req_os, req_hitmap, req_addr, req_domain});
    end
    @(negedge clk);
    cyc++;
    if (!reset_n) begin
      chk("rst_outs", {cache_reset, req_ready, busy, rsp_valid, os_req,
                       user_req, rsp_hit, rsp_os, rsp_domain}, 9'b101000000);
      chk("rst_bus", {hitmap, addr, rsp_addr}, 0);
`ifdef HIT_STATS_EN
      chk("rst_stats", {hits_victim, hits_attacker,
                        miss_victim, miss_attacker}, 0);
`endif
      return;
    end
    if (arm) begin
      hit = hit_val;
      arm = 0;
    end else begin
      hit = 1'($urandom);
    end
    if (init_left > 0)
      init_left--;
    if (due > 0) begin
      due--;
`ifdef HIT_STATS_EN
      if (due == 0 && !rsp_q[0].os) begin
        if (rsp_q[0].dom && rsp_q[0].hit && m_ha != 255) m_ha++;
        if (rsp_q[0].dom && !rsp_q[0].hit && m_ma != 255) m_ma++;
        if (!rsp_q[0].dom && rsp_q[0].hit && m_hv != 255) m_hv++;
        if (!rsp_q[0].dom && !rsp_q[0].hit && m_mv != 255) m_mv++;
      end
`endif
    end
    iss = os_req || user_req;
    if (os_req)
      n_os_cyc++;
    chk("issue_when", iss, exp_issue);
    chk("req_excl", os_req && user_req, 0);
    if (iss) begin
      chk("one_outstanding", rsp_q.size(), 0);
      chk("issue_src", acc_q.size() > 0, 1);
      if (acc_q.size() > 0) begin
        t = acc_q.pop_front();
        chk("issue_kind", {os_req, user_req}, {t.os, !t.os});
        chk("issue_hm", hitmap, t.hm);
        chk("issue_addr", addr, t.a);
        last_hm = t.hm;
        last_a = t.a;
        hv = force_hit ? 1'b1 : 1'($urandom);
        rsp_q.push_back('{t.os ? 1'b0 : hv, t.os, t.dom, t.a});
        due = 2;
        if (!t.os) begin
          arm = 1;
          hit_val = hv;
        end
      end
    end
    chk("port_hold", {hitmap, addr}, {last_hm, last_a});
    chk("cache_reset", cache_reset, init_left > 0);
    chk("req_ready", req_ready, init_left == 0 && acc_q.size() < DEPTH);
    chk("busy", busy,
        init_left > 0 || acc_q.size() > 0 || rsp_q.size() > 0);
    chk("rsp_valid", rsp_valid, rsp_q.size() > 0 && due == 0);
    if (rsp_q.size() > 0 && due == 0)
      chk("rsp_fields", {rsp_hit, rsp_os, rsp_domain, rsp_addr},
          {rsp_q[0].hit, rsp_q[0].os, rsp_q[0].dom, rsp_q[0].a});
`ifdef HIT_STATS_EN
    chk("stats", {hits_victim, hits_attacker, miss_victim, miss_attacker},
        {m_hv, m_ha, m_mv, m_ma});
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int n0;
    int k;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_os     = 1'b0;
    req_hitmap = '0;
    req_addr   = '0;
    req_domain = 1'b0;
    rsp_ready  = 1'b0;
    hit        = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) tick();

    // user lookup that hits
    force_hit  = 1;
    c0         = cyc;
    req_valid  = 1'b1;
    req_os     = 1'b0;
    req_hitmap = '0;
    req_addr   = 16'h0005;
    req_domain = 1'b0;
    tick();
    req_valid = 1'b0;
    while (!rsp_valid && cyc - c0 < 20)
      tick();
    chk("user_latency", cyc - c0, 4);
    chk("user_rsp", {rsp_hit, rsp_os, rsp_addr}, {1'b1, 1'b0, 16'h0005});
    rsp_ready = 1'b1;
    tick();
    force_hit = 0;
    repeat (3) tick();

    // OS hitmap update
    n0         = n_os_cyc;
    req_valid  = 1'b1;
    req_os     = 1'b1;
    req_hitmap = 4'b0011;
    req_addr   = ADDR_WIDTH'($urandom);
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    chk("os_pulse", n_os_cyc - n0, 1);

    // fill the FIFO while responses are stalled
    rsp_ready = 1'b0;
    n0 = n_acc_dut;
    for (int i = 0; i < 10; i++) begin
      rand_req(100);
      tick();
    end
    req_valid = 1'b0;
    chk("fill_count", n_acc_dut - n0, DEPTH + 1);
    chk("fill_ready", req_ready, 0);
    rsp_ready = 1'b1;
    repeat (30) tick();
    chk("drain_idle", busy, 0);

    for (int i = 0; i < 3000; i++) begin
      rand_req(50);
      rsp_ready = ($urandom_range(0, 99) < 60);
      tick();
    end

    // reset while a lookup sits in CAPTURE
    k = 0;
    while (due != 1 && k < 200) begin
      rand_req(70);
      rsp_ready = 1'b1;
      tick();
      k++;
    end
    chk("found_capture", due, 1);
    reset_n   = 1'b0;
    req_valid = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (INITC + 3) tick();
    chk("post_reset_idle", busy, 0);
    for (int i = 0; i < 200; i++) begin
      rand_req(40);
      rsp_ready = 1'b1;
      tick();
    end

`ifdef HIT_STATS_EN
    req_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (INITC + 1) tick();
    force_hit = 1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      req_valid  = 1'b1;
      req_os     = 1'b0;
      req_hitmap = NUM_WAYS'($urandom);
      req_addr   = ADDR_WIDTH'($urandom);
      req_domain = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (4) tick();
    end
    force_hit = 0;
    chk("hits_attacker_sat", hits_attacker, 8'd255);
    chk("hits_victim_zero", hits_victim, 8'd0);
`endif

    req_valid = 1'b0;
    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
